// File: rtl/complex_pkg.sv
// Shared state encoding and default widths
// for the complex divider slice.
package complex_pkg;

  localparam int Q_W_DEF = 16;
  localparam int B_W_DEF = 18;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DIV,
    DONE
  } state_t;

endpackage

// File: rtl/complex_divider_if.sv
// Operand / result handshake bundle
// for complex_divider.
interface complex_divider_if
  import complex_pkg::*;
#(
  parameter int Q_W = Q_W_DEF,
  parameter int B_W = B_W_DEF
);

  localparam int P_W = Q_W + B_W;

  logic                  in_valid;
  logic                  in_ready;
  logic signed [P_W-1:0] real_part_p;
  logic signed [P_W-1:0] imag_part_p;
  logic signed [B_W-1:0] real_part_b;
  logic signed [B_W-1:0] imag_part_b;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [Q_W-1:0] real_output;
  logic signed [Q_W-1:0] imag_output;
  logic                  overflow;
  logic                  div_by_zero;

  modport master (
    output in_valid,
    output real_part_p,
    output imag_part_p,
    output real_part_b,
    output imag_part_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  real_output,
    input  imag_output,
    input  overflow,
    input  div_by_zero
  );

  modport slave (
    input  in_valid,
    input  real_part_p,
    input  imag_part_p,
    input  real_part_b,
    input  imag_part_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output real_output,
    output imag_output,
    output overflow,
    output div_by_zero
  );

endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient
// bit per cycle, MSB first.
module seq_divider #(
  parameter int N_W = 53,
  parameter int D_W = 37,
  parameter int Q_B = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [N_W-1:0] dividend_i,
  input  logic [D_W-1:0] divisor_i,
  output logic           busy_o,
  output logic [Q_B-1:0] quo_o
);

  localparam int S_W = D_W + Q_B - 1;
  localparam int C_W = $clog2(Q_B);

  logic [N_W-1:0] rem_q;
  logic [N_W-1:0] rem_d;
  logic [S_W-1:0] dsh_q;
  logic [Q_B-1:0] quo_q;
  logic [C_W-1:0] cnt_q;
  logic           busy_q;
  logic           fit;

  // Trial subtraction of the aligned divisor.
  always_comb begin
    fit   = rem_q >= N_W'(dsh_q);
    rem_d = rem_q;
    if (fit) rem_d = rem_q - N_W'(dsh_q);
  end

  // Load on start, then one bit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      dsh_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= dividend_i;
      dsh_q  <= S_W'(divisor_i) << (Q_B - 1);
      quo_q  <= '0;
      cnt_q  <= C_W'(Q_B - 1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= rem_d;
      dsh_q <= dsh_q >> 1;
      quo_q <= {quo_q[Q_B-2:0], fit};
      if (cnt_q == '0) busy_q <= 1'b0;
      else cnt_q <= cnt_q - 1'b1;
    end
  end

  assign busy_o = busy_q;
  assign quo_o  = quo_q;

endmodule

// File: rtl/complex_divider.sv
// Complex quotient P*conj(B)/|B|^2 with a
// fixed-latency restoring divider pair.
module complex_divider
  import complex_pkg::*;
#(
  parameter int Q_W = Q_W_DEF,
  parameter int B_W = B_W_DEF
) (
  input logic clk,
  input logic rst_n,
  complex_divider_if.slave bus
);

  localparam int P_W = Q_W + B_W;
  localparam int N_W = P_W + B_W + 1;
  localparam int D_W = 2 * B_W + 1;
  localparam int C_W = $clog2(Q_W - 1);
  localparam logic [C_W-1:0] C_TOP = C_W'(Q_W - 2);
  localparam logic [Q_W-1:0] S_MAX =
    {1'b0, {(Q_W-1){1'b1}}};
  localparam logic [Q_W-1:0] S_MIN =
    {1'b1, {(Q_W-1){1'b0}}};

  state_t state_q, state_d;

  logic signed [P_W-1:0] pr_q, pi_q;
  logic signed [B_W-1:0] br_q, bi_q;
  logic [N_W-1:0] mre_q, mim_q;
  logic           nre_q, nim_q;
  logic [D_W-1:0] den_q;
  logic [C_W-1:0] cnt_q;
  logic           ore_q, oim_q;
  logic [Q_W-1:0] re_q, im_q;
  logic           ovf_q, dbz_q;

  logic signed [N_W-1:0] prx, pix, brx, bix;
  logic signed [N_W-1:0] nre_d, nim_d;
  logic signed [D_W-1:0] brs, bis;
  logic [D_W-1:0] den_d;
  logic [N_W-1:0] mre_d, mim_d, lim;
  logic [Q_W-2:0] qre, qim;
  logic           bre, bim, zero, fin;
  logic [Q_W-1:0] re_d, im_d;

  function automatic logic [Q_W-1:0] fix(
    input logic           ovf,
    input logic           neg,
    input logic [Q_W-2:0] q
  );
    logic [Q_W-1:0] m;
    m = {1'b0, q};
    if (ovf) return neg ? S_MIN : S_MAX;
    return neg ? -m : m;
  endfunction

  assign prx   = N_W'(pr_q);
  assign pix   = N_W'(pi_q);
  assign brx   = N_W'(br_q);
  assign bix   = N_W'(bi_q);
  assign nre_d = prx * brx + pix * bix;
  assign nim_d = pix * brx - prx * bix;
  assign brs   = D_W'(br_q);
  assign bis   = D_W'(bi_q);
  assign den_d = brs * brs + bis * bis;
  assign mre_d = nre_d[N_W-1] ? -nre_d : nre_d;
  assign mim_d = nim_d[N_W-1] ? -nim_d : nim_d;

  // Quotient limit: den scaled by 2^(Q_W-1).
  assign lim  = N_W'({den_q, {(Q_W-1){1'b0}}});
  assign zero = den_q == '0;
  assign fin  = (cnt_q == '0) && !(bre || bim);
  assign re_d = zero ? '0 : fix(ore_q, nre_q, qre);
  assign im_d = zero ? '0 : fix(oim_q, nim_q, qim);

  seq_divider #(
    .N_W(N_W), .D_W(D_W), .Q_B(Q_W - 1)
  ) u_div_re (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (state_q == MULT),
    .dividend_i(mre_d),
    .divisor_i (den_d),
    .busy_o    (bre),
    .quo_o     (qre)
  );

  seq_divider #(
    .N_W(N_W), .D_W(D_W), .Q_B(Q_W - 1)
  ) u_div_im (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (state_q == MULT),
    .dividend_i(mim_d),
    .divisor_i (den_d),
    .busy_o    (bim),
    .quo_o     (qim)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.in_valid) state_d = MULT;
      MULT: state_d = DIV;
      DIV:  if (fin) state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, products, flags, results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr_q  <= '0;
      pi_q  <= '0;
      br_q  <= '0;
      bi_q  <= '0;
      mre_q <= '0;
      mim_q <= '0;
      nre_q <= 1'b0;
      nim_q <= 1'b0;
      den_q <= '0;
      cnt_q <= '0;
      ore_q <= 1'b0;
      oim_q <= 1'b0;
      re_q  <= '0;
      im_q  <= '0;
      ovf_q <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.in_valid) begin
          pr_q <= bus.real_part_p;
          pi_q <= bus.imag_part_p;
          br_q <= bus.real_part_b;
          bi_q <= bus.imag_part_b;
        end
        MULT: begin
          mre_q <= mre_d;
          mim_q <= mim_d;
          nre_q <= nre_d[N_W-1];
          nim_q <= nim_d[N_W-1];
          den_q <= den_d;
          cnt_q <= C_TOP;
        end
        DIV: begin
          if (cnt_q == C_TOP) begin
            ore_q <= mre_q >= lim;
            oim_q <= mim_q >= lim;
          end
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (fin) begin
            re_q  <= re_d;
            im_q  <= im_d;
            dbz_q <= zero;
            ovf_q <= !zero && (ore_q || oim_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = state_q == IDLE;
  assign bus.out_valid   = state_q == DONE;
  assign bus.real_output = re_q;
  assign bus.imag_output = im_q;
  assign bus.overflow    = ovf_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_complex_divider.sv
// Self-checking bench for complex_divider:
// directed table, handshake/reset sequences, random vs model.
module tb_complex_divider;

  localparam int Q_W = 16;
  localparam int B_W = 18;
  localparam int P_W = Q_W + B_W;
  localparam int LAT = Q_W + 1;

  typedef struct {
    string  nm;
    longint pr, pi, br, bi;
    longint er, ei;
    logic   eov, edz;
    int     hold;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[$];

  complex_divider_if #(.Q_W(Q_W), .B_W(B_W)) bus ();

  complex_divider #(.Q_W(Q_W), .B_W(B_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, got, exp);
    end
  endtask

  function automatic longint rnd_s(input int w);
    longint v;
    v = {$urandom, $urandom};
    v = v <<< (64 - w);
    return v >>> (64 - w);
  endfunction

  function automatic vec_t mk(input string nm,
    input longint pr, pi, br, bi, er, ei,
    input logic eov, edz, input int hold);
    vec_t v;
    v.nm = nm; v.pr = pr; v.pi = pi;
    v.br = br; v.bi = bi; v.er = er; v.ei = ei;
    v.eov = eov; v.edz = edz; v.hold = hold;
    return v;
  endfunction

  // Reference: per-component quotient from plain arithmetic.
  function automatic void comp(input longint n, input longint den,
                               output longint q, output logic o);
    longint lim, a;
    lim = longint'(1) << (Q_W - 1);
    a = (n < 0) ? -n : n;
    q = a / den;
    o = 1'b0;
    if (q >= lim) begin
      o = 1'b1;
      q = (n < 0) ? -lim : lim - 1;
    end else if (n < 0) begin
      q = -q;
    end
  endfunction

  function automatic void model(input longint pr, pi, br, bi,
    output longint qr, qi, output logic ov, dz);
    longint nr, ni, den;
    logic o1, o2;
    nr = pr * br + pi * bi;
    ni = pi * br - pr * bi;
    den = br * br + bi * bi;
    qr = 0; qi = 0; ov = 1'b0; dz = 1'b0;
    if (den == 0) begin
      dz = 1'b1;
      return;
    end
    comp(nr, den, qr, o1);
    comp(ni, den, qi, o2);
    ov = o1 | o2;
  endfunction

  task automatic drive_junk();
    bus.real_part_p = P_W'(rnd_s(P_W));
    bus.imag_part_p = P_W'(rnd_s(P_W));
    bus.real_part_b = B_W'(rnd_s(B_W));
    bus.imag_part_b = B_W'(rnd_s(B_W));
  endtask

  task automatic run_op(input string nm,
    input longint pr, pi, br, bi,
    input int hold, input bit skip,
    input longint er, ei, input logic eov, edz);
    int lat;
    bit seen, ok;
    logic signed [Q_W-1:0] hr, hi;
    logic hov, hdz;
    if (!skip) @(negedge clk);
    chk({nm, ".in_ready"}, bus.in_ready, 1);
    bus.real_part_p = P_W'(pr);
    bus.imag_part_p = P_W'(pi);
    bus.real_part_b = B_W'(br);
    bus.imag_part_b = B_W'(bi);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    drive_junk();
    bus.out_ready = (hold == 0);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      seen = bus.out_valid;
    end
    chk({nm, ".latency"}, lat, LAT);
    if (!seen) return;
    chk({nm, ".re"}, bus.real_output, er);
    chk({nm, ".im"}, bus.imag_output, ei);
    chk({nm, ".ovf"}, bus.overflow, eov);
    chk({nm, ".dbz"}, bus.div_by_zero, edz);
    hr = bus.real_output;
    hi = bus.imag_output;
    hov = bus.overflow;
    hdz = bus.div_by_zero;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      drive_junk();
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      ok = bus.out_valid && !bus.in_ready &&
           bus.real_output == hr && bus.imag_output == hi &&
           bus.overflow == hov && bus.div_by_zero == hdz;
      chk({nm, ".hold"}, ok, 1);
    end
    if (hold > 0) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({nm, ".handshake"}, {bus.in_ready, bus.out_valid}, 2);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    longint pr, pi, br, bi, qr, qi, er, ei;
    logic eov, edz;
    bit seen;

    tbl.push_back(mk("ex1", -5, 10, 1, 2, 3, 4, 0, 0, 5));
    tbl.push_back(mk("trunc_pos", 7, 0, 2, 0, 3, 0, 0, 0, 0));
    tbl.push_back(mk("trunc_neg", -7, 0, 2, 0, -3, 0, 0, 0, 1));
    tbl.push_back(mk("sat_pos", 1 << 20, 0, 1, 0, 32767, 0, 1, 0, 0));
    tbl.push_back(mk("sat_neg", -(1 << 20), 0, 1, 0, -32768, 0, 1, 0, 2));
    tbl.push_back(mk("dbz", 123, 456, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("max_ok", 32767, 0, 1, 0, 32767, 0, 0, 0, 0));
    tbl.push_back(mk("edge_ovf", 32768, 0, 1, 0, 32767, 0, 1, 0, 0));
    tbl.push_back(mk("neg_edge", -32768, 0, 1, 0, -32768, 0, 1, 0, 0));
    tbl.push_back(mk("imag_div", 0, -9, 0, 3, -3, 0, 0, 0, 0));
    tbl.push_back(mk("mix_ovf", 1 << 20, 5, 1, 0, 32767, 5, 1, 0, 0));

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.real_part_p = '0;
    bus.imag_part_p = '0;
    bus.real_part_b = '0;
    bus.imag_part_b = '0;

    #1 rst_n = 1'b0;
    #1;
    chk("reset.in_ready", bus.in_ready, 1);
    chk("reset.out_valid", bus.out_valid, 0);
    chk("reset.re", bus.real_output, 0);
    chk("reset.im", bus.imag_output, 0);
    chk("reset.ovf", bus.overflow, 0);
    chk("reset.dbz", bus.div_by_zero, 0);

    #10 rst_n = 1'b1;
    run_op("first_accept", -5, 10, 1, 2, 0, 1, 3, 4, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      run_op(tbl[i].nm, tbl[i].pr, tbl[i].pi, tbl[i].br,
             tbl[i].bi, tbl[i].hold, 0, tbl[i].er, tbl[i].ei,
             tbl[i].eov, tbl[i].edz);
    end

    for (int n = 0; n < 40; n++) begin
      int mode;
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
        pr = rnd_s(P_W); pi = rnd_s(P_W); br = 0; bi = 0;
      end else if (mode < 4) begin
        pr = rnd_s(P_W); pi = rnd_s(P_W);
        br = rnd_s(B_W); bi = rnd_s(B_W);
      end else begin
        br = rnd_s(B_W - 1); bi = rnd_s(B_W - 1);
        qr = rnd_s(Q_W); qi = rnd_s(Q_W);
        pr = qr * br - qi * bi + rnd_s(4);
        pi = qr * bi + qi * br + rnd_s(4);
      end
      model(pr, pi, br, bi, er, ei, eov, edz);
      run_op("rand", pr, pi, br, bi, $urandom_range(0, 2), 0,
             er, ei, eov, edz);
    end

    run_op("pre_rst", 1 << 20, 0, 1, 0, 0, 0, 32767, 0, 1, 0);

    @(negedge clk);
    bus.real_part_p = P_W'(-5);
    bus.imag_part_p = P_W'(10);
    bus.real_part_b = B_W'(1);
    bus.imag_part_b = B_W'(2);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.in_ready", bus.in_ready, 1);
    chk("midrst.out_valid", bus.out_valid, 0);
    chk("midrst.re", bus.real_output, 0);
    chk("midrst.im", bus.imag_output, 0);
    chk("midrst.ovf", bus.overflow, 0);
    chk("midrst.dbz", bus.div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("midrst.no_result", seen, 0);
    run_op("post_rst", -5, 10, 1, 2, 0, 0, 3, 4, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
